// File: rtl/booth_final_adder.sv
// booth_final_adder
// Two-stage carry-propagate adder that resolves the redundant carry/sum pair
// from the Booth multiplier's 4:2 compressor tree into the final product.
// The 2*LENGTH-bit addition is split into a low half (stage 1) and a high
// half (stage 2). Both sides use a valid/ready handshake with full
// backpressure, and the adder sustains one result per cycle.
//
// Ports:
//   sys_clk    rising-edge clock
//   sys_rst    asynchronous active-high reset
//   in_valid   C/D/Co are valid this cycle
//   in_ready   stage 1 can accept this cycle
//   C          compressor carry vector (weight 2)
//   D          compressor sum vector (weight 1)
//   Co         compressor carry-out (weight 2, lands on bit 1)
//   out_valid  P/ovf are valid
//   out_ready  downstream accepts P this cycle
//   P          (2*C + D + 2*Co) mod 2^(2*LENGTH)
//   ovf        the full sum is >= 2^(2*LENGTH)
module booth_final_adder #(
  parameter int LENGTH = 32
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*LENGTH-1:0]   C,
  input  logic [2*LENGTH-1:0]   D,
  input  logic                  Co,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*LENGTH-1:0]   P,
  output logic                  ovf
);

  localparam int W = 2 * LENGTH;

  // Half-width three-operand add, returning {carry, sum}.
  function automatic logic [LENGTH:0] add3(input logic [LENGTH-1:0] a,
                                           input logic [LENGTH-1:0] b,
                                           input logic [LENGTH-1:0] c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

  // X = C << 1 split into halves; C's MSB falls off the 2L-bit word and is
  // carried separately so it can still contribute to ovf.
  logic [LENGTH-1:0] x_lo;
  logic [LENGTH-1:0] x_hi;
  logic [LENGTH-1:0] z_lo;
  logic [LENGTH:0]   sum_lo;
  logic [LENGTH:0]   sum_hi;

  logic              vld_p1;
  logic [LENGTH-1:0] lo_p1;
  logic              c1_p1;
  logic [LENGTH-1:0] xhi_p1;
  logic [LENGTH-1:0] yhi_p1;
  logic              msb_p1;

  logic adv_p1;
  logic adv_p2;
  logic accept;

  assign x_lo = {C[LENGTH-2:0], 1'b0};
  assign x_hi = C[W-2:LENGTH-1];
  assign z_lo = {{(LENGTH-2){1'b0}}, Co, 1'b0};

  // X[0] is always 0, so the low-half carry never exceeds 1.
  assign sum_lo = add3(x_lo, D[LENGTH-1:0], z_lo);
  assign sum_hi = add3(xhi_p1, yhi_p1, {{(LENGTH-1){1'b0}}, c1_p1});

  // Ready ripples backwards combinationally from out_ready; this is the only
  // input-to-output combinational path.
  assign adv_p2   = !out_valid || out_ready;
  assign adv_p1   = vld_p1 && adv_p2;
  assign in_ready = !vld_p1 || adv_p1;
  assign accept   = in_valid && in_ready;

  // ---- stage 1: low half + captured high-half operands ----
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vld_p1 <= 1'b0;
      lo_p1  <= '0;
      c1_p1  <= 1'b0;
      xhi_p1 <= '0;
      yhi_p1 <= '0;
      msb_p1 <= 1'b0;
    end else if (in_ready) begin
      // Stage 1 is either empty or draining this cycle: it takes whatever
      // arrives, or becomes a bubble.
      vld_p1 <= in_valid;
      if (accept) begin
        lo_p1  <= sum_lo[LENGTH-1:0];
        c1_p1  <= sum_lo[LENGTH];
        xhi_p1 <= x_hi;
        yhi_p1 <= D[W-1:LENGTH];
        msb_p1 <= C[W-1];
      end
    end
  end

  // ---- stage 2: high half, result register ----
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      out_valid <= 1'b0;
      P         <= '0;
      ovf       <= 1'b0;
    end else if (adv_p2) begin
      out_valid <= vld_p1;
      if (adv_p1) begin
        P   <= {sum_hi[LENGTH-1:0], lo_p1};
        ovf <= msb_p1 || sum_hi[LENGTH];
      end
    end
  end

endmodule

// File: tb/tb_booth_final_adder.sv
// Self-checking bench for booth_final_adder: directed vectors, backpressure,
// mid-flight reset and randomized traffic against an arithmetic model.
module tb_booth_final_adder;

  localparam int L = 32;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   C;
  logic [63:0]   D;
  logic          Co;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   P;
  logic          ovf;

  int checks   = 0;
  int failures = 0;

  booth_final_adder #(.LENGTH(L)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .C        (C),
    .D        (D),
    .Co       (Co),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .P        (P),
    .ovf      (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer sum of the three weighted operands, {ovf, P}.
  function automatic logic [64:0] model(input logic [63:0] c, input logic [63:0] d,
                                        input logic co);
    logic [65:0] full;
    full = 66'(c) * 66'd2 + 66'(d) + 66'(co) * 66'd2;
    return {(full[65:64] != 2'b00), full[63:0]};
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return {32'h0, $urandom()};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Single transaction with an otherwise idle pipe; checks the 2-edge latency.
  task automatic run_one(input string tag, input logic [63:0] c, input logic [63:0] d,
                         input logic co);
    logic [64:0] e;
    e = model(c, d, co);
    @(negedge sys_clk);
    C = c; D = d; Co = co; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, 65'(in_ready), 65'd1);
    @(negedge sys_clk);
    in_valid = 1'b0;
    #1 chk({tag, "_vld_early"}, 65'(out_valid), 65'd0);
    @(negedge sys_clk);
    #1 chk({tag, "_vld"}, 65'(out_valid), 65'd1);
    chk({tag, "_p"}, 65'(P), 65'(e[63:0]));
    chk({tag, "_ovf"}, 65'(ovf), 65'(e[64]));
  endtask

  initial begin
    logic [64:0] exp_q[$];
    logic [64:0] e;
    int sent;
    int got;
    bit started;
    int stale;

    sys_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    C = '0; D = '0; Co = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_p", 65'(P), 65'd0);
    chk("rst_ovf", 65'(ovf), 65'd0);
    chk("rst_in_ready", 65'(in_ready), 65'd1);

    // Directed vectors: cross-half carry, dropped C MSB, high-half carry-out.
    run_one("c1_carry", 64'h0, 64'h0000_0000_FFFF_FFFF, 1'b1);
    chk("c1_carry_const", 65'(P), {1'b0, 64'h0000_0001_0000_0001});
    run_one("c_msb", 64'h8000_0000_0000_0000, 64'h5, 1'b0);
    run_one("c2_carry", 64'h7FFF_FFFF_FFFF_FFFF, 64'h2, 1'b0);
    chk("c2_carry_const", 65'(P), 65'd0);

    // Backpressure: 5 inputs, outputs stalled for the first 4 cycles.
    sent = 0; got = 0; started = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge sys_clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 5);
      C = '0; Co = 1'b0; D = 64'(sent + 1);
      #1;
      if (cyc == 2 || cyc == 3) begin
        chk("bp_in_ready_low", 65'(in_ready), 65'd0);
        chk("bp_hold_p", 65'(P), 65'd1);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk("bp_order", 65'(P), 65'(got + 1));
        got++;
        started = 1;
      end else if (started && got < 5) begin
        chk("bp_gap", 65'(out_valid), 65'd1);
      end
    end
    chk("bp_count", 65'(got), 65'd5);
    in_valid = 1'b0;

    // Fill the pipe, then reset it mid-flight.
    for (int k = 0; k < 2; k++) begin
      @(negedge sys_clk);
      out_ready = 1'b0; in_valid = 1'b1; C = '0; Co = 1'b0; D = 64'(7 + k);
    end
    @(negedge sys_clk);
    in_valid = 1'b0;
    #1 chk("pre_rst_vld", 65'(out_valid), 65'd1);
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_vld", 65'(out_valid), 65'd0);
    chk("mid_rst_p", 65'(P), 65'd0);
    chk("mid_rst_ovf", 65'(ovf), 65'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", 65'(in_ready), 65'd1);
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      #1 if (out_valid) stale++;
    end
    chk("post_rst_stale", 65'(stale), 65'd0);

    // Randomized traffic with random backpressure.
    sent = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || exp_q.size() > 0); cyc++) begin
      @(negedge sys_clk);
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      C         = rand64();
      D         = rand64();
      Co        = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", 65'(out_valid), 65'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_p", 65'(P), 65'(e[63:0]));
          chk("rnd_ovf", 65'(ovf), 65'(e[64]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(C, D, Co));
        sent++;
      end
    end
    chk("rnd_sent", 65'(sent), 65'd1000);
    chk("rnd_drained", 65'(exp_q.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
